rv16_muldiv_seq: RTL

Iterative sequencer for the RV32M multiply/divide datapath. It sits beside the ALU in execute. The decoder flags an R-type instruction with funct7 = 7'b0000001. Execute then hands the operands and funct3 to this block and stalls until the result returns. One shared shift/add/subtract datapath serves all eight M-extension operations:

- MUL, MULH, MULHSU, MULHU
- DIV, DIVU, REM, REMU

---
 rtl/rv16_pkg.sv | 38 +++
 rtl/rv16_muldiv_step.sv | 55 +++++
 rtl/rv16_muldiv_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv16_pkg.sv
// Shared RV16 core package: M-extension encodings, the mul/div sequencer
// state type and small decode helpers. The decoder, execute stage and the
// mul/div sequencer all import this package.
package rv16_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 that marks an R-type instruction as an M-extension op
    localparam logic [6:0] F7_MULDIV     = 7'b0000001;
    // ALU-op code the decoder uses to route to the mul/div sequencer
    localparam logic [3:0] ALU_OP_MULDIV = 4'b1010;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // within the divide group, funct3[1] selects remainder over quotient
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/rv16_muldiv_step.sv
// One iteration of the shared shift/add/subtract datapath.
// Purely combinational.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in   : {high, low} accumulator; multiply: partial product,
//              divide: {partial remainder, quotient bits so far}
//   a_in     : multiplicand (multiply) / dividend shift register (divide)
//   b_in     : multiplier shift register (multiply) / divisor (divide)
//   acc_out, a_out, b_out : values after this iteration
module rv16_muldiv_step #(
    parameter int unsigned W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc_in,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic [2*W-1:0] acc_out,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out
);

    logic [W:0]   pr;       // 33-bit trial partial remainder
    logic         ge;       // trial remainder >= divisor -> quotient bit 1
    logic [W-1:0] rem_nxt;
    logic [W-1:0] addend;
    logic [W:0]   sum;

    always_comb begin
        acc_out = acc_in;
        a_out   = a_in;
        b_out   = b_in;
        pr      = '0;
        ge      = 1'b0;
        rem_nxt = '0;
        addend  = '0;
        sum     = '0;
        if (is_div) begin
            // Shift the next dividend bit (MSB first) into the remainder.
            pr = {acc_in[2*W-1:W], a_in[W-1]};
            ge = pr[W] | (pr[W-1:0] >= b_in);
            // When ge holds, the true difference is below the divisor, so a
            // W-bit wrapping subtraction yields it exactly even if pr[W]=1.
            rem_nxt = ge ? (pr[W-1:0] - b_in) : pr[W-1:0];
            acc_out = {rem_nxt, acc_in[W-2:0], ge};
            a_out   = {a_in[W-2:0], 1'b0};
        end else begin
            // Add the multiplicand under the current multiplier LSB, then
            // shift the whole 65-bit {carry, product} right by one.
            addend  = b_in[0] ? a_in : '0;
            sum     = {1'b0, acc_in[2*W-1:W]} + {1'b0, addend};
            acc_out = {sum, acc_in[W-1:1]};
            b_out   = {1'b0, b_in[W-1:1]};
        end
    end

endmodule

// File: rtl/rv16_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_start             : request, accepted only while o_ready=1
//   i_funct3            : M-op select, sampled at accept
//   i_rs1, i_rs2        : operands A / B, sampled at accept
//   i_rd                : destination tag, sampled at accept
//   i_kill              : flush, aborts any operation not yet in DONE
//   o_ready             : idle and able to accept
//   o_busy              : iterating or fixing up signs
//   o_done              : one-cycle completion pulse
//   o_result, o_rd      : registered result and tag, valid with o_done
module rv16_muldiv_seq
    import rv16_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t state, state_nxt;

    logic [4:0]        cnt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        rd_out_q;

    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   a_nxt, b_nxt;

    // accept-time decode
    logic            accept;
    logic            a_signed, b_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_result;

    // fixup-time result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign accept = (state == MD_IDLE) && i_start && !i_kill;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (i_funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        neg_a = a_signed & i_rs1[XLEN-1];
        neg_b = b_signed & i_rs2[XLEN-1];
        abs_a = neg_a ? (~i_rs1 + 1'b1) : i_rs1;
        abs_b = neg_b ? (~i_rs2 + 1'b1) : i_rs2;

        div_zero = f3_is_div(i_funct3) && (i_rs2 == '0);
        div_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                   (i_rs1 == INT_MIN) && (i_rs2 == '1);
        fast     = div_zero | div_ovf;

        if (div_zero)
            fast_result = f3_is_rem(i_funct3) ? i_rs1 : '1;
        else
            fast_result = f3_is_rem(i_funct3) ? '0 : INT_MIN;
    end

    rv16_muldiv_step #(
        .W(XLEN)
    ) u_step (
        .is_div (f3_is_div(f3_q)),
        .acc_in (acc),
        .a_in   (a_q),
        .b_in   (b_q),
        .acc_out(acc_nxt),
        .a_out  (a_nxt),
        .b_out  (b_nxt)
    );

    // Operands were iterated as magnitudes; restore signs here. Sign flags
    // are only ever set for signed operands, so unsigned ops pass through.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        quo_fix  = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                        fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_result = quo_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= MD_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE:  if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
            MD_CALC:  if (cnt == 5'd0) state_nxt = MD_FIXUP;
            MD_FIXUP: state_nxt = MD_DONE;
            MD_DONE:  state_nxt = MD_IDLE;
            default:  state_nxt = MD_IDLE;
        endcase
        // a result in DONE is already committed, so kill cannot retract it
        if (i_kill && (state != MD_DONE))
            state_nxt = MD_IDLE;
    end

    // outputs decoded from state
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state)
            MD_IDLE:           o_ready = 1'b1;
            MD_CALC, MD_FIXUP: o_busy  = 1'b1;
            MD_DONE:           o_done  = 1'b1;
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            res_q    <= '0;
            rd_out_q <= '0;
        end else if (accept) begin
            f3_q   <= i_funct3;
            rd_q   <= i_rd;
            sign_a <= neg_a;
            sign_b <= neg_b;
            a_q    <= abs_a;
            b_q    <= abs_b;
            acc    <= '0;
            cnt    <= 5'd31;
            if (fast) begin
                res_q    <= fast_result;
                rd_out_q <= i_rd;
            end
        end else if ((state == MD_CALC) && !i_kill) begin
            acc <= acc_nxt;
            a_q <= a_nxt;
            b_q <= b_nxt;
            cnt <= cnt - 5'd1;
        end else if ((state == MD_FIXUP) && !i_kill) begin
            res_q    <= fix_result;
            rd_out_q <= rd_q;
        end
    end

    assign o_result = res_q;
    assign o_rd     = rd_out_q;

endmodule
